// File: rtl/ether_pkg.sv
// ether_pkg: shared constants and state type for the RMII receive path.
//   state_t         : receiver FSM states
//   PREAMBLE_DIBIT  : preamble dibit value (2'b10)
//   SFD_DIBIT       : start-of-frame-delimiter dibit value (2'b11)
//   PREAMBLE_LEN    : preamble dibits required before the SFD is accepted
//   COUNT_W         : width of the preamble counter
package ether_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        WAIT_END = 2'd3
    } state_t;

    localparam int unsigned        COUNT_W        = 5;
    localparam logic [1:0]         PREAMBLE_DIBIT = 2'b10;
    localparam logic [1:0]         SFD_DIBIT      = 2'b11;
    localparam logic [COUNT_W-1:0] PREAMBLE_LEN   = 5'd31;

endpackage

// File: rtl/ether_rx.sv
// ether_rx: RMII receiver front end. Hunts for a preamble of PREAMBLE_LEN
// dibits followed by the SFD, then forwards every payload dibit with one
// cycle of latency until carrier drops.
//   clk   : sole clock, rising edge
//   rst   : asynchronous reset, active low
//   crsdv : RMII carrier-sense / data-valid
//   rxd   : RMII receive dibit
//   axiov : payload dibit valid (no backpressure)
//   axiod : payload dibit, holds its last value while axiov is low
// Build option: ETHER_RX_STRICT_PREAMBLE_EN -- when defined, a bad dibit in
// the preamble rejects the whole frame (WAIT_END until crsdv drops) instead
// of restarting the preamble count.
module ether_rx
    import ether_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       crsdv,
    input  logic [1:0] rxd,
    output logic       axiov,
    output logic [1:0] axiod
);

    state_t             state, state_n;
    logic [COUNT_W-1:0] count, count_n;
    logic               axiov_n;
    logic [1:0]         axiod_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
            axiov <= 1'b0;
            axiod <= 2'b00;
        end else begin
            state <= state_n;
            count <= count_n;
            axiov <= axiov_n;
            axiod <= axiod_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        axiov_n = 1'b0;
        axiod_n = axiod;

        if (!crsdv) begin
            // Loss of carrier ends any frame, whatever the state.
            state_n = IDLE;
            count_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    // The first carrier dibit already counts toward the preamble.
                    state_n = PREAMBLE;
                    count_n = (rxd == PREAMBLE_DIBIT) ? COUNT_W'(1) : '0;
                end
                PREAMBLE: begin
                    if (rxd == PREAMBLE_DIBIT) begin
                        if (count != '1)
                            count_n = count + 1'b1;
                    end else if (rxd == SFD_DIBIT && count >= PREAMBLE_LEN) begin
                        state_n = DATA;
                    end else begin
                        count_n = '0;
`ifdef ETHER_RX_STRICT_PREAMBLE_EN
                        state_n = WAIT_END;
`endif
                    end
                end
                DATA: begin
                    axiov_n = 1'b1;
                    axiod_n = rxd;
                end
                WAIT_END: begin
                    state_n = WAIT_END;
                end
                default: begin
                    state_n = IDLE;
                    count_n = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ether_rx.sv
// tb_ether_rx: scoreboard bench for ether_rx. Each frame's expected payload
// is derived from the preamble/SFD acceptance rule, pushed with the cycle it
// must appear in, and popped by an independent monitor.
// Build option: ETHER_RX_STRICT_PREAMBLE_EN (must match the RTL build).
module tb_ether_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       crsdv = 1'b0;
    logic [1:0] rxd = 2'b00;
    logic       axiov;
    logic [1:0] axiod;

    ether_rx dut (
        .clk   (clk),
        .rst   (rst),
        .crsdv (crsdv),
        .rxd   (rxd),
        .axiov (axiov),
        .axiod (axiod)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  d;
    } exp_t;

    exp_t        exp_q[$];
    logic [1:0]  fr[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic [1:0]  last_d = 2'b00;
    logic        exp_v;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
        end
    endtask

    // Index of the first payload dibit in fr, or -1 if the frame is rejected.
    // Rule: a run of at least 31 consecutive 10 dibits, then 11. The first
    // carrier dibit only seeds the run; later bad dibits break it (or, in the
    // strict build, reject the frame).
    function automatic int model_start();
        int run = 0;
        for (int i = 0; i < fr.size(); i++) begin
            if (i == 0) begin
                run = (fr[i] == 2'b10) ? 1 : 0;
            end else if (fr[i] == 2'b10) begin
                run++;
            end else if (fr[i] == 2'b11 && run >= 31) begin
                return i + 1;
            end else begin
`ifdef ETHER_RX_STRICT_PREAMBLE_EN
                return -1;
`else
                run = 0;
`endif
            end
        end
        return -1;
    endfunction

    task automatic send_frame(input int gap);
        int start = model_start();
        for (int i = 0; i < fr.size(); i++) begin
            @(negedge clk);
            crsdv = 1'b1;
            rxd   = fr[i];
            if (start >= 0 && i >= start)
                exp_q.push_back('{cyc + 1, fr[i]});
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            crsdv = 1'b0;
            rxd   = 2'($urandom);
        end
    endtask

    task automatic push_pre(input int n);
        for (int i = 0; i < n; i++) fr.push_back(2'b10);
    endtask

    // Monitor: every cycle, axiov must match the scoreboard and axiod must
    // equal the most recent expected payload dibit.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL missed_dibit due_cyc=%0d actual=none required=%b",
                             exp_q[0].cyc, exp_q[0].d);
                    void'(exp_q.pop_front());
                end
                exp_v = (exp_q.size() > 0 && exp_q[0].cyc == cyc);
                check("axiov", {1'b0, axiov}, {1'b0, exp_v});
                if (exp_v) begin
                    last_d = exp_q[0].d;
                    void'(exp_q.pop_front());
                end
                check("axiod", axiod, last_d);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_axiov", {1'b0, axiov}, 2'b00);
        check("reset_axiod", axiod, 2'b00);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Junk, resync, 31 preamble, SFD, short payload
        fr.delete();
        fr.push_back(2'b11); fr.push_back(2'b00); fr.push_back(2'b01);
        push_pre(31);
        fr.push_back(2'b11);
        fr.push_back(2'b11); fr.push_back(2'b01); fr.push_back(2'b01);
        send_frame(3);

        // Preamble one short: whole frame dropped
        fr.delete();
        push_pre(30);
        fr.push_back(2'b11);
        for (int i = 0; i < 12; i++) fr.push_back((i % 2 == 0) ? 2'b01 : 2'b11);
        send_frame(3);

        // Long payload
        fr.delete();
        push_pre(31);
        fr.push_back(2'b11);
        for (int i = 0; i < 6040; i++) fr.push_back((i % 3 == 0) ? 2'b11 : 2'b01);
        send_frame(3);

        // Back-to-back frames with a single idle cycle; the third has a
        // short preamble and must be dropped, proving the count restarted.
        fr.delete();
        push_pre(31); fr.push_back(2'b11);
        for (int i = 0; i < 8; i++) fr.push_back(2'($urandom));
        send_frame(1);
        fr.delete();
        push_pre(31); fr.push_back(2'b11);
        for (int i = 0; i < 8; i++) fr.push_back(2'($urandom));
        send_frame(1);
        fr.delete();
        push_pre(29); fr.push_back(2'b11);
        for (int i = 0; i < 8; i++) fr.push_back(2'($urandom));
        send_frame(2);

        // Randomized frames
        for (int f = 0; f < 200; f++) begin
            fr.delete();
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) fr.push_back(2'($urandom));
            push_pre($urandom_range(26, 40));
            if ($urandom_range(0, 5) == 0) fr.push_back(2'($urandom_range(0, 1)));
            if ($urandom_range(0, 5) == 0) push_pre($urandom_range(0, 33));
            fr.push_back(($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11);
            n = $urandom_range(0, 20);
            for (int i = 0; i < n; i++) fr.push_back(2'($urandom));
            send_frame($urandom_range(1, 4));
        end

        // Reset asserted mid-payload
        fr.delete();
        push_pre(31); fr.push_back(2'b11);
        for (int i = 0; i < 6; i++) fr.push_back(2'b01);
        send_frame(0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        check("pre_reset_axiov", {1'b0, axiov}, 2'b01);
        rst   = 1'b0;
        crsdv = 1'b0;
        #1;
        check("async_reset_axiov", {1'b0, axiov}, 2'b00);
        check("async_reset_axiod", axiod, 2'b00);
        exp_q.delete();
        last_d = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // Fresh frame after reset release
        fr.delete();
        push_pre(31); fr.push_back(2'b11);
        fr.push_back(2'b10); fr.push_back(2'b00); fr.push_back(2'b11);
        send_frame(4);

        repeat (5) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ether_rx.md
ETHER_RX -- requirements
Module: ether_rx

Interface
REQ-001 SHALL have no parameters; all frame constants are fixed in the package.
REQ-002 Port list:
  - clk  input  1  sole clock; all logic on its rising edge.
  - rst  input  1  asynchronous, active-low reset (low = reset).
  - crsdv  input  1  RMII carrier-sense/data-valid.
  - rxd  input  2  RMII receive dibit.
  - axiov  output  1  payload dibit valid.
  - axiod  output  2  payload dibit.

Function
REQ-003 SHALL implement four states:
  - IDLE: waiting for carrier.
  - PREAMBLE: counting consecutive preamble dibits (2'b10).
  - DATA: forwarding payload.
  - WAIT_END: frame rejected; waiting for crsdv low.
REQ-004 IDLE: crsdv=1 SHALL go to PREAMBLE with count=1 if rxd=2'b10, else count=0.
REQ-005 PREAMBLE, crsdv=1, rxd=2'b10: count SHALL increment, saturating at 31.
REQ-006 PREAMBLE, crsdv=1, rxd=2'b11 with count>=31: SHALL go to DATA (SFD accepted; SFD dibit not forwarded).
REQ-007 PREAMBLE, crsdv=1, rxd=2'b11 with count<31: SHALL reset count to 0 and stay in PREAMBLE (resynchronise).
REQ-008 PREAMBLE, crsdv=1, rxd in {2'b00, 2'b01}: SHALL reset count to 0 and stay in PREAMBLE.
REQ-009 DATA, crsdv=1: SHALL register rxd to axiod and set axiov=1 on the next edge (1-cycle latency, every dibit forwarded, no length limit).
REQ-010 Any state, crsdv=0: SHALL go to IDLE, clear count, and drive axiov=0 on the next edge.
REQ-011 axiov SHALL be high only for dibits sampled in DATA; axiod is don't-care-free and SHALL hold its last value when axiov=0.
REQ-012 WAIT_END is entered only from PREAMBLE via the configuration option (REQ-016); otherwise it is unreachable.
REQ-013 No backpressure: the consumer SHALL accept every axiov cycle.

Reset
REQ-014 While rst=0, SHALL asynchronously force: state=IDLE, count=0, axiov=0, axiod=2'b00.
REQ-015 Reset asserted mid-frame SHALL discard the frame; after release, the next crsdv=1 is treated as a new frame start.

Configuration
REQ-016 Macro ETHER_RX_STRICT_PREAMBLE_EN:
  - Defined: in PREAMBLE, any non-10 dibit other than a valid SFD (per REQ-006) SHALL go to WAIT_END; no frame is accepted until crsdv drops.
  - Undefined: resynchronisation per REQ-007/REQ-008 applies.

Structure
REQ-017 Package ether_pkg SHALL hold:
  - state enum
  - PREAMBLE_DIBIT=2'b10
  - SFD_DIBIT=2'b11
  - PREAMBLE_LEN=31
  - count width (5 bits)
REQ-018 SHALL be a single module with no sub-modules; state register, counter and output register all reside in ether_rx.

Verification
REQ-019 Reset: rst=0 mid-DATA -> axiov=0 immediately (no clock); after release, IDLE.
REQ-020 crsdv=1 with dibits 11,00,01, then 31x 10, then 11, then payload 11,01,01 -> macro undefined: axiov=1 for exactly 3 cycles starting the cycle after the first payload dibit, axiod=11,01,01; macro defined: axiov never asserted.
REQ-021 30x 10 then 11, then payload -> axiov stays 0 for the whole frame.
REQ-022 Valid preamble+SFD, then 6040 dibits (11 when i%3==0, else 01), then crsdv=0 -> exactly 6040 axiov cycles with matching axiod; axiov=0 one cycle after crsdv falls.
REQ-023 Two back-to-back frames separated by one crsdv=0 cycle -> both payloads forwarded and count restarts at 0 for the second frame.
